long_digit_tx: RTL
==================

LONG_DIGIT_TX -- requirements
Module: long_digit_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bit width of one limb.
REQ-002 SHALL have parameter L, default 4: number of limbs; limb L-1 is most significant.
REQ-003 SHALL have parameter INT_DIGITS, default 2: number of integer limbs, which are limbs L-1 down to L-INT_DIGITS.
REQ-004 SHALL have parameter MAX, default 10000: limb radix; only 10000 is supported, giving 4 decimal digits per limb.
REQ-005 SHALL have port ck, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port a, input, [L-1:0][WIDTH-1:0]: long fixed-point value, sampled only on an accepted start.
REQ-008 SHALL have port start, input, 1 bit: request to serialize a; accepted only in IDLE or DONE.
REQ-009 SHALL have port sym, output, 4 bits: output symbol, 0-9 for a decimal digit, 4'hA for the decimal point.
REQ-010 SHALL have port sym_valid, output, 1 bit: sym holds a valid symbol.
REQ-011 SHALL have port sym_ready, input, 1 bit: the downstream sink accepts sym.
REQ-012 SHALL have port busy, output, 1 bit: high from an accepted start until the last symbol is accepted.
REQ-013 SHALL have port finish, output, 1 bit: high from completion of the last transfer until the next accepted start.
REQ-014 SHALL have port err, output, 1 bit: sticky flag, set when any sampled limb is >= MAX.

Function
REQ-015 SHALL implement the states IDLE, LOAD, EXTRACT, EMIT, POINT and DONE.
REQ-016 SHALL, in IDLE or DONE with start=1, register a into an internal buffer, clear finish, set busy, set limb index to L-1, and enter LOAD on the next cycle.
REQ-017 SHALL ignore start in LOAD, EXTRACT, EMIT and POINT, leaving the buffer unchanged.
REQ-018 SHALL, in LOAD, copy buffer[limb index] into a WIDTH-bit working remainder; if the limb is >= MAX, set err and load MAX-1 instead.
REQ-019 SHALL, in EXTRACT, compute each digit by repeated subtraction of weights 1000, 100, 10 and 1, one subtraction per cycle, without any divider or multiplier.
REQ-020 SHALL count each digit up while remainder >= weight (at most 9 cycles per digit), then enter EMIT.
REQ-021 SHALL, in EMIT, drive sym=digit with sym_valid=1, holding sym stable until sym_ready=1.
REQ-022 SHALL count a transfer only on a cycle where sym_valid and sym_ready are both high.
REQ-023 SHALL, after a transfer, return to EXTRACT with the next weight, or, after weight 1, go to the limb-end decision.
REQ-024 SHALL, at limb-end, enter POINT if the limb just finished is L-INT_DIGITS and limb index > 0.
REQ-025 SHALL, at limb-end otherwise, decrement the limb index and enter LOAD if the index was > 0.
REQ-026 SHALL, at limb-end with limb index 0, enter DONE.
REQ-027 SHALL, in POINT, drive sym=4'hA with sym_valid=1; after transfer, decrement the limb index and enter LOAD.
REQ-028 SHALL emit exactly 4*L+1 symbols per frame, MSB first, with leading zeros kept and no suppression.
REQ-029 SHALL, in DONE, drive busy=0 and finish=1, holding finish until the next accepted start.
REQ-030 SHALL accept start in DONE on the same edge finish is observed, with finish dropping on the next cycle.
REQ-031 SHALL never combinationally depend sym_valid on sym_ready.
REQ-032 SHALL keep sym_valid=0 in IDLE, LOAD, EXTRACT and DONE.
REQ-033 SHALL make a change of a after an accepted start have no effect on the current frame.
REQ-034 SHALL clear err only at the next accepted start or on reset.

Reset
REQ-035 SHALL, on rst=1, take state IDLE immediately without waiting for ck.
REQ-036 SHALL, on rst=1, force sym=0, sym_valid=0, busy=0, finish=0 and err=0, and clear the limb index, buffer and remainder.
REQ-037 SHALL, on rst asserted mid-frame, abort the frame with no further symbols, and start the next frame only on a fresh start.

Verification
REQ-038 SHALL check: a={0,3,1415,9265}, start pulse, sym_ready=1 constantly -> 0,0,0,0,0,0,0,3,A,1,4,1,5,9,2,6,5, then finish=1, err=0.
REQ-039 SHALL check: same frame with sym_ready toggling pseudo-randomly -> identical 17-symbol sequence, with sym held stable while stalled.
REQ-040 SHALL check: a={9999,9999,9999,9999} -> 8 nines, A, 8 nines; the per-digit extraction takes 9 cycles.
REQ-041 SHALL check: limb a[1]=12000 -> err=1, and that limb is emitted as 9,9,9,9.
REQ-042 SHALL check: rst asserted while in EMIT of limb 1 -> sym_valid=0 and busy=0 asynchronously, with no symbols until the next start.
REQ-043 SHALL check: start asserted mid-frame and a changed -> ignored, and the original frame completes unchanged.

Source files
------------

// File: rtl/long_digit_tx.sv
// Serializes a multi-limb base-10000 fixed-point value as decimal digit symbols,
// MSB first, with a decimal-point symbol after the last integer limb.
module long_digit_tx #(
  parameter int WIDTH      = 16,
  parameter int L          = 4,
  parameter int INT_DIGITS = 2,
  parameter int MAX        = 10000
) (
  input  logic                      ck,
  input  logic                      rst,
  input  logic [L-1:0][WIDTH-1:0]   a,
  input  logic                      start,
  output logic [3:0]                sym,
  output logic                      sym_valid,
  input  logic                      sym_ready,
  output logic                      busy,
  output logic                      finish,
  output logic                      err
);

  localparam int IW = (L > 1) ? $clog2(L) : 1;
  localparam logic [WIDTH-1:0] MAXW   = WIDTH'(MAX);
  localparam logic [IW-1:0]    PT_IDX = IW'(L - INT_DIGITS);

  typedef enum logic [2:0] {IDLE, LOAD, EXTRACT, EMIT, POINT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [L-1:0][WIDTH-1:0] limbs_q, limbs_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [WIDTH-1:0]        rem_q, rem_d;
  logic [3:0]              digit_q, digit_d;
  logic [1:0]              wsel_q, wsel_d;
  logic                    err_q, err_d;
  logic [WIDTH-1:0]        weight, rem_sub;

  always_comb begin
    case (wsel_q)
      2'd0:    weight = WIDTH'(1000);
      2'd1:    weight = WIDTH'(100);
      2'd2:    weight = WIDTH'(10);
      default: weight = WIDTH'(1);
    endcase
    rem_sub = rem_q - weight;
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      limbs_q <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      digit_q <= '0;
      wsel_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      limbs_q <= limbs_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      digit_q <= digit_d;
      wsel_q  <= wsel_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    limbs_d   = limbs_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    digit_d   = digit_q;
    wsel_d    = wsel_q;
    err_d     = err_q;
    sym       = '0;
    sym_valid = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          limbs_d = a;
          err_d   = 1'b0;
          idx_d   = IW'(L - 1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (limbs_q[idx_q] >= MAXW) begin
          rem_d = MAXW - WIDTH'(1);
          err_d = 1'b1;
        end else begin
          rem_d = limbs_q[idx_q];
        end
        digit_d = '0;
        wsel_d  = '0;
        state_d = EXTRACT;
      end
      EXTRACT: begin
        // Look ahead on the difference so a digit of n costs n cycles (min 1).
        if (rem_q >= weight) begin
          rem_d   = rem_sub;
          digit_d = digit_q + 4'd1;
          if (rem_sub < weight) state_d = EMIT;
        end else begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        sym       = digit_q;
        sym_valid = 1'b1;
        if (sym_ready) begin
          digit_d = '0;
          if (wsel_q != 2'd3) begin
            wsel_d  = wsel_q + 2'd1;
            state_d = EXTRACT;
          end else if (idx_q == PT_IDX && idx_q != '0) begin
            state_d = POINT;
          end else if (idx_q != '0) begin
            idx_d   = idx_q - IW'(1);
            state_d = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      POINT: begin
        sym       = 4'hA;
        sym_valid = 1'b1;
        if (sym_ready) begin
          idx_d   = idx_q - IW'(1);
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q != IDLE) && (state_q != DONE);
  assign finish = (state_q == DONE);
  assign err    = err_q;

endmodule
